// File: rtl/cmd_packet_assembler.sv
// rtl/cmd_packet_assembler.sv - assembles I2C byte strobes into command packets and buffers them in a packet FIFO
// Optional macro CMD_TIMEOUT_EN: discard a partial packet after TIMEOUT_CYC idle clocks.
module cmd_packet_assembler #(
  parameter int          MAX_BYTES   = 11,
  parameter int          DEPTH       = 4,
  parameter logic [63:0] LEN_TABLE   = 64'h00000000000000B0,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [7:0]             cmd,
  input  logic [7:0]             i2c_in_data,
  input  logic                   i2c_rts,
  output logic                   i2c_busy,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [7:0]             pkt_cmd,
  output logic [3:0]             pkt_len,
  output logic [8*MAX_BYTES-1:0] pkt_data,
  output logic                   err_unknown,
  output logic                   err_proto,
  output logic                   err_overflow,
  output logic                   err_timeout
);
  localparam int DW = 8 * MAX_BYTES;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0] MAX_LEN = 5'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            unknown_d, proto_d, overflow_d;
  logic [3:0]      lut_len;
  logic            known, push, pop, timeout;

  logic [7:0]      fifo_cmd  [DEPTH];
  logic [3:0]      fifo_len  [DEPTH];
  logic [DW-1:0]   fifo_data [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  assign lut_len = (cmd[7:4] == 4'd0) ? LEN_TABLE[{cmd[3:0], 2'b00} +: 4] : 4'd0;
  assign known   = (lut_len != 4'd0) && ({1'b0, lut_len} <= MAX_LEN);

  assign pkt_valid = (count != '0);
  assign pop       = pkt_valid && pkt_ready;
  assign i2c_busy  = (state_q == PUSH);
  assign pkt_cmd   = pkt_valid ? fifo_cmd[rd_ptr]  : 8'd0;
  assign pkt_len   = pkt_valid ? fifo_len[rd_ptr]  : 4'd0;
  assign pkt_data  = pkt_valid ? fifo_data[rd_ptr] : '0;

`ifdef CMD_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYC) + 1;
  logic [GW-1:0] gap_q;

  assign timeout = (state_q == COLLECT) && !i2c_rts && (gap_q == GW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      gap_q <= '0;
    end else if (i2c_rts && state_q != PUSH) begin
      gap_q <= '0;
    end else if (state_q == COLLECT) begin
      gap_q <= gap_q + GW'(1);
    end
  end
`else
  assign timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  // A byte whose opcode differs from the packet in progress restarts assembly as if from IDLE.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    unknown_d  = 1'b0;
    proto_d    = 1'b0;
    overflow_d = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (i2c_rts) begin
          if (state_q == COLLECT && cmd == cmd_q) begin
            data_d = (data_q << 8) | DW'(i2c_in_data);
            cnt_d  = cnt_q + 4'd1;
            if (cnt_d == len_q) state_d = PUSH;
          end else begin
            proto_d = (state_q == COLLECT);
            state_d = IDLE;
            cnt_d   = 4'd0;
            if (known) begin
              cmd_d   = cmd;
              len_d   = lut_len;
              data_d  = DW'(i2c_in_data);
              cnt_d   = 4'd1;
              state_d = (lut_len == 4'd1) ? PUSH : COLLECT;
            end else begin
              unknown_d = 1'b1;
            end
          end
        end else if (timeout) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      PUSH: begin
        overflow_d = i2c_rts;
        if (count != CW'(DEPTH) || pop) begin
          push    = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= IDLE;
      cmd_q        <= 8'd0;
      len_q        <= 4'd0;
      cnt_q        <= 4'd0;
      data_q       <= '0;
      err_unknown  <= 1'b0;
      err_proto    <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      err_unknown  <= unknown_d;
      err_proto    <= proto_d;
      err_overflow <= overflow_d;
      err_timeout  <= timeout;
    end
  end

  // Push and pop in the same cycle leave the occupancy unchanged, even when full.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cmd[wr_ptr]  <= cmd_q;
      fifo_len[wr_ptr]  <= len_q;
      fifo_data[wr_ptr] <= data_q;
    end
  end
endmodule

// File: tb/tb_cmd_packet_assembler.sv
// tb/tb_cmd_packet_assembler.sv - randomized self-checking bench for cmd_packet_assembler against a packet-queue model
module tb_cmd_packet_assembler;
  localparam int          MB = 11;
  localparam int          DP = 2;
  localparam int          TO = 16;
  localparam logic [63:0] LT = 64'h000000000F0031B0;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic [7:0]    cmd = 8'd0;
  logic [7:0]    i2c_in_data = 8'd0;
  logic          i2c_rts = 1'b0;
  logic          i2c_busy;
  logic          pkt_valid;
  logic          pkt_ready = 1'b0;
  logic [7:0]    pkt_cmd;
  logic [3:0]    pkt_len;
  logic [8*MB-1:0] pkt_data;
  logic          err_unknown, err_proto, err_overflow, err_timeout;

  cmd_packet_assembler #(.MAX_BYTES(MB), .DEPTH(DP), .LEN_TABLE(LT), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_(rst_), .cmd(cmd), .i2c_in_data(i2c_in_data), .i2c_rts(i2c_rts),
    .i2c_busy(i2c_busy), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_cmd(pkt_cmd),
    .pkt_len(pkt_len), .pkt_data(pkt_data), .err_unknown(err_unknown), .err_proto(err_proto),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      cmd;
    logic [3:0]      len;
    logic [8*MB-1:0] data;
  } pkt_t;

  pkt_t       fifo_q[$];
  pkt_t       pend;
  bit         pend_v;
  logic [7:0] part_b[$];
  logic [7:0] part_cmd;
  int         gap;
  bit         e_unk, e_proto, e_ovf, e_to;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] fr [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h0F, 8'h00, 8'h00};

  function automatic int len_of(logic [7:0] c);
    int l;
    if (c[7:4] != 4'd0) return 0;
    l = int'((LT >> (4 * c[3:0])) & 64'hF);
    if (l == 0 || l > MB) return 0;
    return l;
  endfunction

  function automatic pkt_t make_pkt();
    pkt_t p;
    int   n;
    p = '0;
    n = part_b.size();
    p.cmd = part_cmd;
    p.len = 4'(n);
    for (int k = 0; k < n; k++) p.data[8*(n-1-k) +: 8] = part_b[k];
    return p;
  endfunction

  function automatic logic [105:0] exp_snap();
    pkt_t h;
    h = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    return {fifo_q.size() > 0, pend_v, e_unk, e_proto, e_ovf, e_to, h.cmd, h.len, h.data};
  endfunction

  function automatic logic [105:0] obs_snap();
    return {pkt_valid, i2c_busy, err_unknown, err_proto, err_overflow, err_timeout, pkt_cmd, pkt_len, pkt_data};
  endfunction

  task automatic model_clear();
    fifo_q.delete();
    part_b.delete();
    pend_v = 0;
    gap = 0;
    e_unk = 0; e_proto = 0; e_ovf = 0; e_to = 0;
  endtask

  // Drives one clock of inputs and advances the packet-level model across that edge.
  task automatic step(input bit rts, input logic [7:0] c, input logic [7:0] d, input bit rdy);
    bit   pop, do_push;
    pkt_t p;
    i2c_rts = rts; cmd = c; i2c_in_data = d; pkt_ready = rdy;
    e_unk = 0; e_proto = 0; e_ovf = 0; e_to = 0;
    pop = rdy && fifo_q.size() > 0;
    do_push = 0;
    if (pend_v) begin
      if (rts) e_ovf = 1;
      if (fifo_q.size() < DP || pop) do_push = 1;
    end else if (rts) begin
      gap = 0;
      if (part_b.size() > 0 && c != part_cmd) begin
        e_proto = 1;
        part_b.delete();
      end
      if (part_b.size() > 0) part_b.push_back(d);
      else if (len_of(c) == 0) e_unk = 1;
      else begin
        part_cmd = c;
        part_b.push_back(d);
      end
      if (part_b.size() > 0 && part_b.size() == len_of(part_cmd)) begin
        pend = make_pkt();
        pend_v = 1;
        part_b.delete();
      end
    end
`ifdef CMD_TIMEOUT_EN
    else if (part_b.size() > 0) begin
      if (gap == TO - 1) begin
        e_to = 1;
        part_b.delete();
      end else gap++;
    end
`endif
    @(posedge clk);
    #1;
    if (pop) p = fifo_q.pop_front();
    if (do_push) begin
      fifo_q.push_back(pend);
      pend_v = 0;
    end
    i2c_rts = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_ = 1'b0;
    model_clear();
    #2;
    checks++;
    if (obs_snap() !== 106'd0) begin
      failures++;
      $display("FAIL reset_async obs=%h exp=0", obs_snap());
    end
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  task automatic test_reset();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_snap() !== 106'd0) begin
      failures++;
      $display("FAIL reset_state obs=%h exp=0", obs_snap());
    end
    rst_ = 1'b1;
  endtask

  task automatic test_fill_rect();
    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < 10; j++) begin
        step(j == 0, 8'h01, fr[k], 1'b0);
        checks++;
        if (obs_snap() !== exp_snap()) begin
          failures++;
          $display("FAIL fill_rect_cycle b=%0d j=%0d obs=%h exp=%h", k, j, obs_snap(), exp_snap());
        end
        if (k == 10 && j == 0) begin
          checks++;
          if (pkt_valid !== 1'b0 || i2c_busy !== 1'b1) begin
            failures++;
            $display("FAIL fill_rect_last_edge valid=%b busy=%b exp valid=0 busy=1", pkt_valid, i2c_busy);
          end
        end
      end
    end
    checks++;
    if ({pkt_valid, pkt_cmd, pkt_len, pkt_data} !== {1'b1, 8'h01, 4'd11, 88'h00000000020002000F0000}) begin
      failures++;
      $display("FAIL fill_rect_packet obs=%b/%h/%0d/%h exp=1/01/11/00000000020002000F0000",
               pkt_valid, pkt_cmd, pkt_len, pkt_data);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_rect_drain valid=%b exp=0", pkt_valid);
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 12; k++) begin
        step(k < 11, 8'h01, 8'($urandom), 1'b0);
        checks++;
        if (obs_snap() !== exp_snap()) begin
          failures++;
          $display("FAIL backpressure_fill p=%0d k=%0d obs=%h exp=%h", n, k, obs_snap(), exp_snap());
        end
      end
    end
    checks++;
    if (i2c_busy !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_busy busy=%b exp=1", i2c_busy);
    end
    step(1'b1, 8'h01, 8'hAA, 1'b0);
    checks++;
    if (err_overflow !== 1'b1 || obs_snap() !== exp_snap()) begin
      failures++;
      $display("FAIL backpressure_overflow ovf=%b obs=%h exp=%h", err_overflow, obs_snap(), exp_snap());
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00, 8'h00, k != 1);
      checks++;
      if (obs_snap() !== exp_snap()) begin
        failures++;
        $display("FAIL backpressure_drain k=%0d obs=%h exp=%h", k, obs_snap(), exp_snap());
      end
    end
    checks++;
    if (pkt_valid !== 1'b0 || i2c_busy !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_empty valid=%b busy=%b exp=0/0", pkt_valid, i2c_busy);
    end
  endtask

  task automatic test_unknown();
    logic [7:0] bad [3] = '{8'h05, 8'h16, 8'h06};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, bad[k], 8'($urandom), 1'b0);
      checks++;
      if (err_unknown !== 1'b1 || obs_snap() !== exp_snap()) begin
        failures++;
        $display("FAIL unknown_pulse cmd=%h unk=%b obs=%h exp=%h", bad[k], err_unknown, obs_snap(), exp_snap());
      end
      step(1'b0, 8'h00, 8'h00, 1'b0);
      checks++;
      if (err_unknown !== 1'b0 || obs_snap() !== exp_snap()) begin
        failures++;
        $display("FAIL unknown_clear cmd=%h unk=%b exp=0", bad[k], err_unknown);
      end
    end
  endtask

  task automatic test_proto();
    for (int k = 0; k < 4; k++) step(1'b1, 8'h01, 8'($urandom), 1'b0);
    step(1'b1, 8'h02, 8'h5C, 1'b0);
    checks++;
    if (err_proto !== 1'b1 || i2c_busy !== 1'b1) begin
      failures++;
      $display("FAIL proto_pulse proto=%b busy=%b exp=1/1", err_proto, i2c_busy);
    end
    step(1'b0, 8'h00, 8'h00, 1'b0);
    checks++;
    if ({pkt_valid, pkt_cmd, pkt_len, pkt_data} !== {1'b1, 8'h02, 4'd1, 88'h5C}) begin
      failures++;
      $display("FAIL proto_packet obs=%b/%h/%0d/%h exp=1/02/1/5c", pkt_valid, pkt_cmd, pkt_len, pkt_data);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if (obs_snap() !== exp_snap() || pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL proto_drain obs=%h exp=%h", obs_snap(), exp_snap());
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) step(1'b1, 8'h01, 8'hEE, 1'b0);
    pulse_reset();
    for (int k = 0; k < 13; k++) begin
      step(k < 11, 8'h01, (k < 11) ? fr[k] : 8'h00, k == 12);
      checks++;
      if (obs_snap() !== exp_snap()) begin
        failures++;
        $display("FAIL reset_mid k=%0d obs=%h exp=%h", k, obs_snap(), exp_snap());
      end
      if (k == 11) begin
        checks++;
        if (pkt_data !== 88'h00000000020002000F0000) begin
          failures++;
          $display("FAIL reset_mid_data obs=%h exp=00000000020002000F0000", pkt_data);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int pulses;
    int n;
    pulses = 0;
    for (int k = 0; k < 3; k++) step(1'b1, 8'h01, 8'($urandom), 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0);
      if (err_timeout) pulses++;
      checks++;
      if (obs_snap() !== exp_snap()) begin
        failures++;
        $display("FAIL timeout_idle k=%0d obs=%h exp=%h", k, obs_snap(), exp_snap());
      end
    end
    checks++;
`ifdef CMD_TIMEOUT_EN
    if (pulses != 1 || pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_count pulses=%0d valid=%b exp=1/0", pulses, pkt_valid);
    end
`else
    if (pulses != 0) begin
      failures++;
      $display("FAIL timeout_disabled pulses=%0d exp=0", pulses);
    end
`endif
    n = (part_b.size() > 0) ? 11 - part_b.size() : 11;
    for (int k = 0; k < n + 2; k++) begin
      step(k < n, 8'h01, 8'($urandom), k == n + 1);
      checks++;
      if (obs_snap() !== exp_snap()) begin
        failures++;
        $display("FAIL timeout_followup k=%0d obs=%h exp=%h", k, obs_snap(), exp_snap());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [8] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h05, 8'h16, 8'h06};
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 2) != 0, ops[$urandom_range(0, 7)], 8'($urandom), $urandom_range(0, 2) == 0);
      checks++;
      if (obs_snap() !== exp_snap()) begin
        failures++;
        $display("FAIL random k=%0d obs=%h exp=%h", k, obs_snap(), exp_snap());
      end
    end
    for (int k = 0; k < 6; k++) step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if (obs_snap() !== exp_snap() || pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL random_drain obs=%h exp=%h", obs_snap(), exp_snap());
    end
  endtask

  initial begin
    test_reset();
    test_fill_rect();
    test_backpressure();
    test_unknown();
    test_proto();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
